bp_update_sched: RTL and testbench

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

---
 rtl/bp_update_sched_pkg.sv | 25 ++
 rtl/bp_update_sched_if.sv | 52 +++++
 rtl/bp_update_sched_arb.sv | 39 +++
 rtl/bp_update_sched.sv | 166 ++++++++++++++++
 tb/tb_bp_update_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_sched_pkg.sv
// Shared types and configuration constants for the branch-predictor update scheduler.
// Holds the queue entry struct, default sizes and the round-robin selector enum.
package bp_update_sched_pkg;

    // Configuration defaults
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 32;

    // Widest address an entry can carry; narrower builds zero-extend into it
    localparam int ADDR_W_MAX = 64;

    // Round-robin selector: which requester wins when both are valid
    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_sel_e;

    // One queued predictor update
    typedef struct packed {
        logic [ADDR_W_MAX-1:0] pc;
        logic [ADDR_W_MAX-1:0] npc;
        logic                  taken;
    } bp_entry_t;

endpackage

// File: rtl/bp_update_sched_if.sv
// Handshake/payload bundle between the two update requesters and the predictor.
// master: requesters + predictor side (drives valid/payload/stall/clear); slave: scheduler.
interface bp_update_sched_if
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    // Requester A (branch unit)
    logic              a_valid;
    logic [ADDR_W-1:0] a_pc;
    logic [ADDR_W-1:0] a_npc;
    logic              a_taken;
    logic              a_ready;

    // Requester B (jump/commit unit)
    logic              b_valid;
    logic [ADDR_W-1:0] b_pc;
    logic [ADDR_W-1:0] b_npc;
    logic              b_taken;
    logic              b_ready;

    // Predictor side
    logic              stall;
    logic              clear;
    logic              predict_update;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] branch_npc;
    logic              actual_result;

    logic [$clog2(DEPTH):0] count;

    modport master (
        output a_valid, a_pc, a_npc, a_taken,
        output b_valid, b_pc, b_npc, b_taken,
        output stall, clear,
        input  a_ready, b_ready,
        input  predict_update, branch_pc, branch_npc, actual_result,
        input  count
    );

    modport slave (
        input  a_valid, a_pc, a_npc, a_taken,
        input  b_valid, b_pc, b_npc, b_taken,
        input  stall, clear,
        output a_ready, b_ready,
        output predict_update, branch_pc, branch_npc, actual_result,
        output count
    );

endinterface

// File: rtl/bp_update_sched_arb.sv
// bp_rr_arbiter: 2-way round-robin winner select and last-granted pointer.
// Ports: clk_i, rst_ni, req_a_i/req_b_i (valids), gnt_a_i/gnt_b_i (transfers), win_a_o.
module bp_rr_arbiter
    import bp_update_sched_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic gnt_a_i,
    input  logic gnt_b_i,
    output logic win_a_o
);

    rr_sel_e prio_q;

    // A lone requester always wins; the pointer only breaks ties
    always_comb begin
        win_a_o = (prio_q == RR_A);
        if (req_a_i && !req_b_i) begin
            win_a_o = 1'b1;
        end else if (!req_a_i && req_b_i) begin
            win_a_o = 1'b0;
        end
    end

    // After a single grant, favour the side that was not served.
    // A double grant serves both, so the pointer is left alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= RR_A;
        end else if (gnt_a_i && !gnt_b_i) begin
            prio_q <= RR_B;
        end else if (gnt_b_i && !gnt_a_i) begin
            prio_q <= RR_A;
        end
    end

endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: queues resolved-branch updates from two requesters and drains one per cycle.
// Ports: clk, rst (async active-low), bus (slave modport); BP_UPDATE_BYPASS_EN enables empty-queue bypass.
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    bp_update_sched_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW:0] FREE_MAX = (CW+1)'(DEPTH);
    localparam logic [CW:0] FREE_ONE = (CW+1)'(1);
    localparam logic [CW:0] FREE_TWO = (CW+1)'(2);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] tail_p1;
    logic [CW-1:0] count_q, count_d;

    bp_entry_t mem_q [DEPTH];
    bp_entry_t out_q;
    logic      pu_q;

    bp_entry_t a_ent, b_ent, hd_ent, byp_ent;
    bp_entry_t wr0_ent, wr1_ent;
    logic      wr0_en, wr1_en;

    logic          drain;
    logic [CW:0]   free;
    logic          win_a;
    logic          rdy_a, rdy_b;
    logic          xfer_a, xfer_b;
    logic          bypass;

    bp_rr_arbiter u_arb (
        .clk_i   (clk),
        .rst_ni  (rst),
        .req_a_i (bus.a_valid),
        .req_b_i (bus.b_valid),
        .gnt_a_i (xfer_a),
        .gnt_b_i (xfer_b),
        .win_a_o (win_a)
    );

    // Handshake and drain decision
    always_comb begin
        drain = (count_q != '0) && !bus.stall && !bus.clear;
        // A drain this cycle frees one slot for an incoming write
        free  = FREE_MAX - {1'b0, count_q} + {{CW{1'b0}}, drain};
        rdy_a = rst && !bus.clear && (win_a ? (free >= FREE_ONE) : (free >= FREE_TWO));
        rdy_b = rst && !bus.clear && (!win_a ? (free >= FREE_ONE) : (free >= FREE_TWO));
        xfer_a = bus.a_valid && rdy_a;
        xfer_b = bus.b_valid && rdy_b;
`ifdef BP_UPDATE_BYPASS_EN
        bypass = (count_q == '0) && !bus.stall && !bus.clear && (xfer_a ^ xfer_b);
`else
        bypass = 1'b0;
`endif
    end

    // Payload packing and write-port steering
    always_comb begin
        a_ent       = '0;
        a_ent.pc    = ADDR_W_MAX'(bus.a_pc);
        a_ent.npc   = ADDR_W_MAX'(bus.a_npc);
        a_ent.taken = bus.a_taken;
        b_ent       = '0;
        b_ent.pc    = ADDR_W_MAX'(bus.b_pc);
        b_ent.npc   = ADDR_W_MAX'(bus.b_npc);
        b_ent.taken = bus.b_taken;

        hd_ent  = mem_q[head_q];
        byp_ent = xfer_a ? a_ent : b_ent;

        wr0_en  = 1'b0;
        wr1_en  = 1'b0;
        wr0_ent = a_ent;
        wr1_ent = b_ent;
        // A always takes the lower slot when both are accepted
        if (!bypass) begin
            if (xfer_a) begin
                wr0_en = 1'b1;
                wr1_en = xfer_b;
            end else if (xfer_b) begin
                wr0_en  = 1'b1;
                wr0_ent = b_ent;
            end
        end
        tail_p1 = tail_q + PW'(1);
    end

    // Pointer and occupancy next-state
    always_comb begin
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(wr0_en) + PW'(wr1_en);
        count_d = count_q - CW'(drain) + CW'(wr0_en) + CW'(wr1_en);
        if (bus.clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr0_en) begin
                mem_q[tail_q] <= wr0_ent;
            end
            if (wr1_en) begin
                mem_q[tail_p1] <= wr1_ent;
            end
        end
    end

    // Output register: payload holds between strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pu_q  <= 1'b0;
            out_q <= '0;
        end else begin
            pu_q <= drain || bypass;
            if (drain) begin
                out_q <= hd_ent;
            end else if (bypass) begin
                out_q <= byp_ent;
            end
        end
    end

    // Zero-extended upper address bits are never driven out
    if (ADDR_W < ADDR_W_MAX) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^{out_q.pc[ADDR_W_MAX-1:ADDR_W], out_q.npc[ADDR_W_MAX-1:ADDR_W]};
    end

    assign bus.a_ready        = rdy_a;
    assign bus.b_ready        = rdy_b;
    assign bus.predict_update = pu_q;
    assign bus.branch_pc      = out_q.pc[ADDR_W-1:0];
    assign bus.branch_npc     = out_q.npc[ADDR_W-1:0];
    assign bus.actual_result  = out_q.taken;
    assign bus.count          = count_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed testbench for bp_update_sched (DEPTH=4, ADDR_W=32).
// Immediate-assertion checks with hand-computed expectations; one summary line.
module tb_bp_update_sched;
    import bp_update_sched_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_update_sched_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    bp_update_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [31:0] pc, input logic [31:0] npc, input logic t);
        bus.a_valid = v;
        bus.a_pc    = pc;
        bus.a_npc   = npc;
        bus.a_taken = t;
    endtask

    task automatic set_b(input logic v, input logic [31:0] pc, input logic [31:0] npc, input logic t);
        bus.b_valid = v;
        bus.b_pc    = pc;
        bus.b_npc   = npc;
        bus.b_taken = t;
    endtask

    initial begin
        rst = 1'b0;
        set_a(1'b0, 32'h0, 32'h0, 1'b0);
        set_b(1'b0, 32'h0, 32'h0, 1'b0);
        bus.stall = 1'b0;
        bus.clear = 1'b0;
        #3;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_pu", 64'(bus.predict_update), 64'd0);
        chk("rst_pc", 64'(bus.branch_pc), 64'd0);
        chk("rst_npc", 64'(bus.branch_npc), 64'd0);
        chk("rst_res", 64'(bus.actual_result), 64'd0);
        chk("rst_ardy", 64'(bus.a_ready), 64'd0);
        chk("rst_brdy", 64'(bus.b_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single A request
        tick();
        set_a(1'b1, 32'h100, 32'h200, 1'b1);
        #1;
        chk("single_ardy", 64'(bus.a_ready), 64'd1);
        tick();
        set_a(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef BP_UPDATE_BYPASS_EN
        chk("byp_count", 64'(bus.count), 64'd0);
        chk("byp_pu", 64'(bus.predict_update), 64'd1);
        chk("byp_pc", 64'(bus.branch_pc), 64'h100);
        chk("byp_npc", 64'(bus.branch_npc), 64'h200);
        chk("byp_res", 64'(bus.actual_result), 64'd1);
        tick();
        chk("byp_pu_off", 64'(bus.predict_update), 64'd0);
        chk("byp_pc_hold", 64'(bus.branch_pc), 64'h100);
`else
        chk("single_count1", 64'(bus.count), 64'd1);
        chk("single_pu0", 64'(bus.predict_update), 64'd0);
        tick();
        chk("single_pu", 64'(bus.predict_update), 64'd1);
        chk("single_pc", 64'(bus.branch_pc), 64'h100);
        chk("single_npc", 64'(bus.branch_npc), 64'h200);
        chk("single_res", 64'(bus.actual_result), 64'd1);
        chk("single_count0", 64'(bus.count), 64'd0);
        tick();
        chk("single_pu_off", 64'(bus.predict_update), 64'd0);
        chk("single_pc_hold", 64'(bus.branch_pc), 64'h100);
`endif

        // A and B together on an empty queue
        set_a(1'b1, 32'h110, 32'h114, 1'b1);
        set_b(1'b1, 32'h220, 32'h224, 1'b0);
        #1;
        chk("dual_ardy", 64'(bus.a_ready), 64'd1);
        chk("dual_brdy", 64'(bus.b_ready), 64'd1);
        tick();
        set_a(1'b0, 32'h0, 32'h0, 1'b0);
        set_b(1'b0, 32'h0, 32'h0, 1'b0);
        chk("dual_count", 64'(bus.count), 64'd2);
        tick();
        chk("dual_pu_a", 64'(bus.predict_update), 64'd1);
        chk("dual_pc_a", 64'(bus.branch_pc), 64'h110);
        chk("dual_res_a", 64'(bus.actual_result), 64'd1);
        tick();
        chk("dual_pu_b", 64'(bus.predict_update), 64'd1);
        chk("dual_pc_b", 64'(bus.branch_pc), 64'h220);
        chk("dual_npc_b", 64'(bus.branch_npc), 64'h224);
        chk("dual_res_b", 64'(bus.actual_result), 64'd0);
        chk("dual_count0", 64'(bus.count), 64'd0);
        tick();
        chk("dual_pu_off", 64'(bus.predict_update), 64'd0);

        // Stall with 6 requests: only 4 fit
        bus.stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_a(1'b1, 32'h300 + 32'(4 * i), 32'h900 + 32'(i), 1'b1);
            #1;
            chk("stall_ardy", 64'(bus.a_ready), (i < 4) ? 64'd1 : 64'd0);
            chk("stall_pu", 64'(bus.predict_update), 64'd0);
            tick();
        end
        set_a(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("stall_count", 64'(bus.count), 64'd4);
        chk("stall_brdy", 64'(bus.b_ready), 64'd0);
        bus.stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_drain_pu", 64'(bus.predict_update), 64'd1);
            chk("stall_drain_pc", 64'(bus.branch_pc), 64'h300 + 64'(4 * k));
            chk("stall_drain_cnt", 64'(bus.count), 64'(3 - k));
        end
        tick();
        chk("stall_drain_end", 64'(bus.predict_update), 64'd0);

        // Full queue + drain + both valid: B is favoured (A served alone last)
        bus.stall = 1'b1;
        set_a(1'b1, 32'h400, 32'h0, 1'b0);
        set_b(1'b1, 32'h404, 32'h0, 1'b0);
        tick();
        set_a(1'b1, 32'h408, 32'h0, 1'b0);
        set_b(1'b1, 32'h40C, 32'h0, 1'b0);
        tick();
        chk("full_count", 64'(bus.count), 64'd4);
        bus.stall = 1'b0;
        set_a(1'b1, 32'h500, 32'h0, 1'b1);
        set_b(1'b1, 32'h504, 32'h0, 1'b1);
        #1;
        chk("full_ardy", 64'(bus.a_ready), 64'd0);
        chk("full_brdy", 64'(bus.b_ready), 64'd1);
        tick();
        set_a(1'b0, 32'h0, 32'h0, 1'b0);
        set_b(1'b0, 32'h0, 32'h0, 1'b0);
        chk("full_count_hold", 64'(bus.count), 64'd4);
        chk("full_pc0", 64'(bus.branch_pc), 64'h400);
        tick();
        chk("full_pc1", 64'(bus.branch_pc), 64'h404);
        tick();
        chk("full_pc2", 64'(bus.branch_pc), 64'h408);
        tick();
        chk("full_pc3", 64'(bus.branch_pc), 64'h40C);
        tick();
        chk("full_pc4", 64'(bus.branch_pc), 64'h504);
        chk("full_res4", 64'(bus.actual_result), 64'd1);
        chk("full_count0", 64'(bus.count), 64'd0);
        tick();

        // Clear with count=3
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 32'h600 + 32'(4 * i), 32'h0, 1'b1);
            tick();
        end
        chk("clr_count3", 64'(bus.count), 64'd3);
        bus.stall = 1'b0;
        bus.clear = 1'b1;
        #1;
        chk("clr_ardy", 64'(bus.a_ready), 64'd0);
        chk("clr_brdy", 64'(bus.b_ready), 64'd0);
        tick();
        bus.clear = 1'b0;
        set_a(1'b0, 32'h0, 32'h0, 1'b0);
        chk("clr_count0", 64'(bus.count), 64'd0);
        chk("clr_pu", 64'(bus.predict_update), 64'd0);
        tick();
        chk("clr_pu_next", 64'(bus.predict_update), 64'd0);

        // Reset mid-operation
        set_a(1'b1, 32'h700, 32'h710, 1'b1);
        set_b(1'b1, 32'h704, 32'h714, 1'b1);
        tick();
        set_a(1'b0, 32'h0, 32'h0, 1'b0);
        set_b(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("mid_pu", 64'(bus.predict_update), 64'd1);
        chk("mid_pc", 64'(bus.branch_pc), 64'h700);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_pu", 64'(bus.predict_update), 64'd0);
        chk("mid_rst_pc", 64'(bus.branch_pc), 64'd0);
        chk("mid_rst_npc", 64'(bus.branch_npc), 64'd0);
        chk("mid_rst_res", 64'(bus.actual_result), 64'd0);
        chk("mid_rst_count", 64'(bus.count), 64'd0);
        chk("mid_rst_ardy", 64'(bus.a_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("post_rst_pu", 64'(bus.predict_update), 64'd0);
        chk("post_rst_count", 64'(bus.count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
